// File: rtl/umi_regfile_responder.sv
// UMI responder endpoint: a 16 x 32-bit register file that executes single-word
// read/write/posted requests and returns responses with src/dst addresses swapped.
module umi_regfile_responder #(
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          umi_in_valid,
  output logic          umi_in_ready,
  input  logic [CW-1:0] umi_in_cmd,
  input  logic [AW-1:0] umi_in_dstaddr,
  input  logic [AW-1:0] umi_in_srcaddr,
  input  logic [DW-1:0] umi_in_data,
  output logic          umi_out_valid,
  input  logic          umi_out_ready,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data
);

  localparam logic [4:0] OP_REQ_READ   = 5'h01;
  localparam logic [4:0] OP_REQ_WRITE  = 5'h03;
  localparam logic [4:0] OP_REQ_POSTED = 5'h05;
  localparam logic [4:0] OP_RESP_READ  = 5'h02;
  localparam logic [4:0] OP_RESP_WRITE = 5'h04;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   regs_q [16];
  logic [31:0]   regs_d [16];
  logic [CW-1:0] cmd_q, cmd_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] src_q, src_d;
  logic [31:0]   data_q, data_d;

  logic [4:0]  opcode;
  logic [2:0]  size;
  logic [7:0]  len;
  logic [3:0]  idx;
  logic        legal;
  logic        accept;
  logic        is_read;
  logic        is_write;
  logic        is_posted;
  logic [31:0] wmask;
  logic [31:0] wdata;
  logic        unused_data;

  // Only the low word of the data bus carries payload.
  assign unused_data = ^umi_in_data[DW-1:32];

  always_comb begin
    opcode    = umi_in_cmd[4:0];
    size      = umi_in_cmd[7:5];
    len       = umi_in_cmd[15:8];
    idx       = umi_in_dstaddr[5:2];
    legal     = (umi_in_dstaddr[11:6] == 6'd0) && (len == 8'd0) && (size <= 3'd2);
    accept    = umi_in_valid && (state_q == IDLE);
    is_read   = (opcode == OP_REQ_READ);
    is_write  = (opcode == OP_REQ_WRITE);
    is_posted = (opcode == OP_REQ_POSTED);

    // Narrow writes replicate the low payload bits across lanes, then mask.
    case (size)
      3'd0: begin
        wmask = 32'h0000_00FF << {umi_in_dstaddr[1:0], 3'b000};
        wdata = {4{umi_in_data[7:0]}};
      end
      3'd1: begin
        wmask = umi_in_dstaddr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wdata = {2{umi_in_data[15:0]}};
      end
      default: begin
        wmask = 32'hFFFF_FFFF;
        wdata = umi_in_data[31:0];
      end
    endcase

    state_d = state_q;
    cmd_d   = cmd_q;
    dst_d   = dst_q;
    src_d   = src_q;
    data_d  = data_q;
    for (int i = 0; i < 16; i++) regs_d[i] = regs_q[i];

    if (accept && legal && (is_write || is_posted))
      regs_d[idx] = (regs_q[idx] & ~wmask) | (wdata & wmask);

    case (state_q)
      IDLE: begin
        if (accept && (is_read || is_write)) begin
          state_d        = RESP;
          cmd_d          = umi_in_cmd;
          cmd_d[4:0]     = is_read ? OP_RESP_READ : OP_RESP_WRITE;
          cmd_d[25:24]   = legal ? 2'b00 : 2'b10;
          dst_d          = umi_in_srcaddr;
          src_d          = umi_in_dstaddr;
          data_d         = (is_read && legal) ? regs_q[idx] : 32'h0;
        end
      end
      RESP: begin
        if (umi_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      data_q  <= '0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      data_q  <= data_d;
      for (int i = 0; i < 16; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign umi_in_ready    = (state_q == IDLE);
  assign umi_out_valid   = (state_q == RESP);
  assign umi_out_cmd     = cmd_q;
  assign umi_out_dstaddr = dst_q;
  assign umi_out_srcaddr = src_q;
  assign umi_out_data    = {{(DW-32){1'b0}}, data_q};

endmodule

// File: tb/tb_umi_regfile_responder.sv
// Self-checking bench for umi_regfile_responder with a register-array reference model.
module tb_umi_regfile_responder;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_cmd = '0;
  logic [63:0]  in_dst = '0;
  logic [63:0]  in_src = '0;
  logic [255:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_cmd;
  logic [63:0]  out_dst;
  logic [63:0]  out_src;
  logic [255:0] out_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] reg_m [16];

  umi_regfile_responder #(.CW(32), .AW(64), .DW(256)) dut (
    .clk(clk), .reset(reset),
    .umi_in_valid(in_valid), .umi_in_ready(in_ready),
    .umi_in_cmd(in_cmd), .umi_in_dstaddr(in_dst), .umi_in_srcaddr(in_src), .umi_in_data(in_data),
    .umi_out_valid(out_valid), .umi_out_ready(out_ready),
    .umi_out_cmd(out_cmd), .umi_out_dstaddr(out_dst), .umi_out_srcaddr(out_src), .umi_out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk_cmd(input logic [4:0] op, input logic [2:0] size,
                                         input logic [7:0] len, input logic [15:0] hi);
    return {hi[15:10], 2'b00, hi[7:0], len, size, op};
  endfunction

  function automatic bit m_legal(input logic [31:0] cmd, input logic [63:0] dst);
    return (dst[11:6] == 6'd0) && (cmd[15:8] == 8'd0) && (cmd[7:5] <= 3'd2);
  endfunction

  function automatic void m_write(input logic [31:0] cmd, input logic [63:0] dst, input logic [255:0] data);
    int idx;
    int sh;
    idx = int'(dst[5:2]);
    if (!m_legal(cmd, dst)) return;
    case (cmd[7:5])
      3'd0: begin
        sh = int'(dst[1:0]) * 8;
        reg_m[idx] = (reg_m[idx] & ~(32'hFF << sh)) | (32'(data[7:0]) << sh);
      end
      3'd1: begin
        sh = int'(dst[1]) * 16;
        reg_m[idx] = (reg_m[idx] & ~(32'hFFFF << sh)) | (32'(data[15:0]) << sh);
      end
      default: reg_m[idx] = data[31:0];
    endcase
  endfunction

  // Expected response tuple {valid, cmd, dst, src, data} for a non-posted request.
  function automatic logic [416:0] m_resp(input logic [31:0] cmd, input logic [63:0] dst,
                                          input logic [63:0] src);
    logic [31:0] ecmd;
    logic [31:0] edata;
    bit lg;
    lg = m_legal(cmd, dst);
    ecmd = cmd;
    ecmd[4:0] = (cmd[4:0] == 5'h01) ? 5'h02 : 5'h04;
    ecmd[25:24] = lg ? 2'b00 : 2'b10;
    edata = (cmd[4:0] == 5'h01 && lg) ? reg_m[int'(dst[5:2])] : 32'h0;
    return {1'b1, ecmd, src, dst, 224'h0, edata};
  endfunction

  task automatic xact(input logic [31:0] cmd, input logic [63:0] dst, input logic [63:0] src,
                      input logic [255:0] data, output bit acc, output logic [416:0] obs);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_cmd = cmd; in_dst = dst; in_src = src; in_data = data;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    obs = {out_valid, out_cmd, out_dst, out_src, out_data};
    if (out_valid && out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL reset_hs got=%b exp=10", {in_ready, out_valid});
    end
    checks++;
    if ({out_cmd, out_dst, out_src, out_data} !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", {out_cmd, out_dst, out_src, out_data});
    end
  endtask

  task automatic test_write_read;
    bit acc;
    logic [416:0] obs, exp;
    logic [31:0] c;
    c = mk_cmd(5'h03, 3'd2, 8'd0, 16'h0);
    exp = m_resp(c, 64'h08, 64'h1234);
    xact(c, 64'h08, 64'h1234, 256'hDEADBEEF, acc, obs);
    m_write(c, 64'h08, 256'hDEADBEEF);
    checks++;
    if (!acc || obs !== exp) begin
      errors++; $display("FAIL write_resp got=%h exp=%h", obs, exp);
    end
    c = mk_cmd(5'h01, 3'd2, 8'd0, 16'h0);
    xact(c, 64'h08, 64'h1234, 256'h0, acc, obs);
    checks++;
    if (obs[255:0] !== 256'hDEADBEEF) begin
      errors++; $display("FAIL read_data got=%h exp=deadbeef", obs[255:0]);
    end
  endtask

  task automatic test_byte_lane;
    bit acc;
    logic [416:0] obs;
    logic [31:0] c;
    c = mk_cmd(5'h05, 3'd0, 8'd0, 16'h0);
    xact(c, 64'h09, 64'h55, 256'hAA, acc, obs);
    m_write(c, 64'h09, 256'hAA);
    checks++;
    if (!acc || obs[416] !== 1'b0) begin
      errors++; $display("FAIL posted_no_resp got_valid=%b acc=%b exp_valid=0", obs[416], acc);
    end
    xact(mk_cmd(5'h01, 3'd2, 8'd0, 16'h0), 64'h08, 64'h1, 256'h0, acc, obs);
    checks++;
    if (obs[255:0] !== 256'hDEADAAEF) begin
      errors++; $display("FAIL byte_lane_read got=%h exp=deadaaef", obs[255:0]);
    end
  endtask

  task automatic test_backpressure;
    bit acc;
    logic [416:0] snap, exp, obs;
    logic [31:0] c;
    c = mk_cmd(5'h01, 3'd2, 8'd0, 16'h0);
    exp = m_resp(c, 64'h08, 64'h77);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_cmd = c; in_dst = 64'h08; in_src = 64'h77; in_data = '0;
    @(posedge clk);
    #1;
    // keep a posted write valid while the response is stalled; it must not be taken
    in_cmd = mk_cmd(5'h05, 3'd2, 8'd0, 16'h0); in_dst = 64'h0C; in_data = 256'h5555_5555;
    snap = {out_valid, out_cmd, out_dst, out_src, out_data};
    checks++;
    if (snap !== exp) begin
      errors++; $display("FAIL bp_first got=%h exp=%h", snap, exp);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, out_cmd, out_dst, out_src, out_data} !== {1'b0, exp}) begin
        errors++; $display("FAIL bp_hold[%0d] in_ready=%b got=%h exp=%h", i, in_ready,
                           {out_valid, out_cmd, out_dst, out_src, out_data}, exp);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL bp_release got=%b exp=10", {in_ready, out_valid});
    end
    xact(c, 64'h0C, 64'h1, 256'h0, acc, obs);
    checks++;
    if (obs[31:0] !== reg_m[3]) begin
      errors++; $display("FAIL bp_no_consume got=%h exp=%h", obs[31:0], reg_m[3]);
    end
  endtask

  task automatic test_illegal;
    bit acc;
    logic [416:0] obs, exp;
    logic [31:0] c;
    c = mk_cmd(5'h01, 3'd2, 8'd0, 16'h0);
    exp = {1'b1, 32'h0200_0042, 64'h99, 64'h40, 256'h0};
    xact(c, 64'h40, 64'h99, 256'h0, acc, obs);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL illegal_read got=%h exp=%h", obs, exp);
    end
    c = mk_cmd(5'h03, 3'd2, 8'd3, 16'h0);
    exp = {1'b1, 32'h0200_0344, 64'h98, 64'h08, 256'h0};
    xact(c, 64'h08, 64'h98, 256'h1234_5678, acc, obs);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL illegal_write got=%h exp=%h", obs, exp);
    end
    xact(mk_cmd(5'h01, 3'd2, 8'd0, 16'h0), 64'h08, 64'h1, 256'h0, acc, obs);
    checks++;
    if (obs[255:0] !== 256'hDEADAAEF) begin
      errors++; $display("FAIL illegal_write_unchanged got=%h exp=deadaaef", obs[255:0]);
    end
  endtask

  task automatic test_back_to_back;
    bit acc;
    bit all_acc;
    logic [416:0] obs;
    int c0;
    logic [31:0] c;
    c = mk_cmd(5'h05, 3'd2, 8'd0, 16'h0);
    all_acc = 1'b1;
    @(negedge clk);
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      xact(c, 64'(i * 4), 64'h0, 256'(i), acc, obs);
      all_acc &= acc;
      m_write(c, 64'(i * 4), 256'(i));
    end
    checks++;
    if (!all_acc || (cyc - c0) != 17) begin
      errors++; $display("FAIL burst_cycles got=%0d exp=17 acc=%b", cyc - c0, all_acc);
    end
    for (int i = 0; i < 16; i++) begin
      xact(mk_cmd(5'h01, 3'd2, 8'd0, 16'h0), 64'(i * 4), 64'h0, 256'h0, acc, obs);
      checks++;
      if (obs[255:0] !== 256'(i)) begin
        errors++; $display("FAIL burst_read[%0d] got=%h exp=%0d", i, obs[255:0], i);
      end
    end
  endtask

  task automatic test_random;
    bit acc;
    logic [416:0] obs, exp;
    logic [31:0] c;
    logic [63:0] dst, src;
    logic [255:0] data;
    logic [4:0] op;
    int r;
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      op = (r < 3) ? 5'h01 : (r < 6) ? 5'h03 : (r < 9) ? 5'h05 : 5'($urandom_range(6, 31));
      c = mk_cmd(op, 3'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0) ? 8'd1 : 8'd0,
                 16'($urandom));
      dst = {$urandom, $urandom};
      if ($urandom_range(0, 7) != 0) dst[11:6] = 6'd0;
      src = {$urandom, $urandom};
      data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      exp = m_resp(c, dst, src);
      xact(c, dst, src, data, acc, obs);
      if (op == 5'h03 || op == 5'h05) m_write(c, dst, data);
      checks++;
      if (op == 5'h01 || op == 5'h03) begin
        if (!acc || obs !== exp) begin
          errors++; $display("FAIL rand_resp[%0d] got=%h exp=%h", n, obs, exp);
        end
      end else if (!acc || obs[416] !== 1'b0) begin
        errors++; $display("FAIL rand_noresp[%0d] op=%h got_valid=%b acc=%b", n, op, obs[416], acc);
      end
    end
    for (int i = 0; i < 16; i++) begin
      xact(mk_cmd(5'h01, 3'd2, 8'd0, 16'h0), 64'(i * 4), 64'h0, 256'h0, acc, obs);
      checks++;
      if (obs[255:0] !== {224'h0, reg_m[i]}) begin
        errors++; $display("FAIL rand_final[%0d] got=%h exp=%h", i, obs[31:0], reg_m[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit acc;
    logic [416:0] obs;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_cmd = mk_cmd(5'h01, 3'd2, 8'd0, 16'h0); in_dst = 64'h04; in_src = 64'h3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_pending got=%b exp=1", out_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL rstmid_async got=%b exp=10", {in_ready, out_valid});
    end
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) reg_m[i] = '0;
    for (int i = 0; i < 16; i++) begin
      xact(mk_cmd(5'h01, 3'd2, 8'd0, 16'h0), 64'(i * 4), 64'h0, 256'h0, acc, obs);
      checks++;
      if (!acc || obs[255:0] !== {224'h0, reg_m[i]}) begin
        errors++; $display("FAIL rstmid_clear[%0d] got=%h exp=0", i, obs[255:0]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) reg_m[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_write_read();
    test_byte_lane();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
